// File: rtl/rv32imf_irq_claim_ctrl.sv
// Claims external interrupt sources round-robin onto the core's fast IRQ lines irq[31:16].
// Optional build macro RV32IMF_IRQ_NESTING_EN enables one level of preemption with a 1-entry id stack.
module rv32imf_irq_claim_ctrl #(
  parameter int unsigned          NUM_SRC   = 16,
  parameter logic [NUM_SRC-1:0]   EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  output logic [31:0]        irq_o,
  input  logic               irq_ack_i,
  input  logic [4:0]         irq_ack_id_i,
  input  logic               complete_i,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               active_o,
  output logic [4:0]         active_id_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_SVC = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_s, eligible_s, cand_s;
  logic [3:0]         rr_ptr_q, rr_ptr_d, sel_q, sel_d, pick_s, act_idx_s;
  logic [4:0]         idx_s;
  logic               pick_vld_s, ack_match_s, withdraw_s;
  logic [31:0]        irq_q, irq_d;
  logic               active_q, active_d;
  logic [4:0]         active_id_q, active_id_d;
`ifdef RV32IMF_IRQ_NESTING_EN
  logic               stk_vld_q, stk_vld_d;
  logic [4:0]         stk_id_q, stk_id_d;
`endif

  // Ids are 16+i, so the low nibble of the active id is the source index.
  assign act_idx_s   = active_id_q[3:0];
  assign ack_match_s = (state_q == S_REQ) && irq_ack_i && (irq_ack_id_i == {1'b1, sel_q});
  assign withdraw_s  = !pending_q[sel_q] || !src_en_i[sel_q];
  assign eligible_s  = pending_q & src_en_i & ~in_service_s;

  // Sources currently claimed (active and, when nesting, the stacked one)
  always_comb begin
    in_service_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_q && (act_idx_s == 4'(i))) begin
        in_service_s[i] = 1'b1;
      end else begin
        in_service_s[i] = 1'b0;
      end
`ifdef RV32IMF_IRQ_NESTING_EN
      if (stk_vld_q && (stk_id_q[3:0] == 4'(i))) begin
        in_service_s[i] = 1'b1;
      end else begin
        in_service_s[i] = in_service_s[i];
      end
`endif
    end
  end

  // Candidates for arbitration; in service only strictly higher indices may preempt
  always_comb begin
    cand_s = eligible_s;
`ifdef RV32IMF_IRQ_NESTING_EN
    if (state_q == S_SVC) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (stk_vld_q || (4'(i) <= act_idx_s)) begin
          cand_s[i] = 1'b0;
        end else begin
          cand_s[i] = eligible_s[i];
        end
      end
    end else begin
      cand_s = eligible_s;
    end
`endif
  end

  // Round-robin pick: first candidate at or above rr_ptr, wrapping
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = 4'd0;
    idx_s      = 5'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_s = 5'(rr_ptr_q) + 5'(k);
      if (idx_s >= 5'(NUM_SRC)) begin
        idx_s = idx_s - 5'(NUM_SRC);
      end else begin
        idx_s = idx_s;
      end
      if (!pick_vld_s && cand_s[idx_s[3:0]]) begin
        pick_vld_s = 1'b1;
        pick_s     = idx_s[3:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Pending capture: edge sources latch rising edges (set beats ack-clear), level sources follow src_i
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = (src_i[i] & ~src_q[i]) |
                       (pending_q[i] & ~(ack_match_s && (sel_q == 4'(i))));
      end else begin
        pending_d[i] = src_i[i];
      end
    end
  end

  // Claim FSM next-state and registered-output values
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    irq_d       = irq_q;
    rr_ptr_d    = rr_ptr_q;
    active_d    = active_q;
    active_id_d = active_id_q;
`ifdef RV32IMF_IRQ_NESTING_EN
    stk_vld_d   = stk_vld_q;
    stk_id_d    = stk_id_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld_s) begin
          sel_d                  = pick_s;
          irq_d                  = 32'd0;
          irq_d[{1'b1, pick_s}]  = 1'b1;
          state_d                = S_REQ;
        end else begin
          irq_d = 32'd0;
        end
      end
      S_REQ: begin
        if (ack_match_s) begin
          irq_d       = 32'd0;
          active_d    = 1'b1;
          active_id_d = {1'b1, sel_q};
          state_d     = S_SVC;
`ifdef RV32IMF_IRQ_NESTING_EN
          stk_vld_d   = active_q;
          stk_id_d    = active_q ? active_id_q : 5'd0;
`endif
        end else if (withdraw_s) begin
          irq_d   = 32'd0;
          state_d = active_q ? S_SVC : S_IDLE;
        end else begin
          irq_d = irq_q;
        end
      end
      S_SVC: begin
        if (complete_i) begin
          rr_ptr_d = (act_idx_s == 4'(NUM_SRC - 1)) ? 4'd0 : act_idx_s + 4'd1;
`ifdef RV32IMF_IRQ_NESTING_EN
          if (stk_vld_q) begin
            active_id_d = stk_id_q;
            stk_vld_d   = 1'b0;
            stk_id_d    = 5'd0;
          end else begin
            active_d    = 1'b0;
            active_id_d = 5'd0;
            state_d     = S_IDLE;
          end
        end else if (pick_vld_s) begin
          sel_d                 = pick_s;
          irq_d                 = 32'd0;
          irq_d[{1'b1, pick_s}] = 1'b1;
          state_d               = S_REQ;
`else
          active_d    = 1'b0;
          active_id_d = 5'd0;
          state_d     = S_IDLE;
`endif
        end else begin
          irq_d = 32'd0;
        end
      end
      default: begin
        irq_d       = 32'd0;
        active_d    = 1'b0;
        active_id_d = 5'd0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset clears irq_o immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= 4'd0;
      sel_q       <= 4'd0;
      irq_q       <= 32'd0;
      active_q    <= 1'b0;
      active_id_q <= 5'd0;
`ifdef RV32IMF_IRQ_NESTING_EN
      stk_vld_q   <= 1'b0;
      stk_id_q    <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_i;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      irq_q       <= irq_d;
      active_q    <= active_d;
      active_id_q <= active_id_d;
`ifdef RV32IMF_IRQ_NESTING_EN
      stk_vld_q   <= stk_vld_d;
      stk_id_q    <= stk_id_d;
`endif
    end
  end

  assign irq_o       = irq_q;
  assign pending_o   = pending_q;
  assign active_o    = active_q;
  assign active_id_o = active_id_q;

endmodule
